// File: rtl/clk_div_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Holds the FSM state encoding and the default counter and rollover widths.
package clk_div_mon_pkg;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOCK_CYCLES = 4;
  localparam int ROLL_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } mon_state_e;

endpackage

// File: rtl/div_edge_det.sv
// Registers a clk-synchronous level and reports its rising/falling edges.
// The edge outputs are combinational, valid in the cycle before the registered copy updates.
module div_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) din_q <= 1'b0;
    else      din_q <= din;
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of one divided clock in clk_in cycles and checks them
// against expected values, reporting per-period errors, lock, timeout and a rise count.
module clk_div_monitor
  import clk_div_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic              div_in,
  input  logic [CNT_W-1:0]  exp_period,
  input  logic [CNT_W-1:0]  exp_high,
  output logic [CNT_W-1:0]  period_meas,
  output logic [CNT_W-1:0]  high_meas,
  output logic              meas_valid,
  output logic              period_err,
  output logic              duty_err,
  output logic              err_sticky,
  output logic              locked,
  output logic              timeout,
  output logic [ROLL_W-1:0] rise_count,
  output mon_state_e        state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [3:0]       good;
  logic             rise, fall;
  logic             meas_done, meas_bad, timeout_hit, fall_cap;

  div_edge_det u_edge (
    .clk  (clk_in),
    .rst  (rst),
    .din  (div_in),
    .rise (rise),
    .fall (fall)
  );

  // en low wins over any same-cycle edge; a rise in MEAS closes a period.
  always_comb begin
    state_d     = state_q;
    meas_done   = 1'b0;
    timeout_hit = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          if (rise) state_d = ST_MEAS;
          else if (cnt == CNT_MAX) timeout_hit = 1'b1;
        end
        ST_MEAS: begin
          if (rise) begin
            meas_done = 1'b1;
          end else if (cnt == CNT_MAX) begin
            timeout_hit = 1'b1;
            state_d     = ST_ARM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign meas_bad  = meas_done && ((cnt != exp_period) || (high_meas != exp_high));
  assign fall_cap  = en && (state_q == ST_MEAS) && fall;
  assign locked    = (good == LOCK_MAX);
  assign state_dbg = state_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // meas_valid is a single-cycle strobe with no back-pressure: period_meas, high_meas,
  // period_err and duty_err are meaningful in exactly the cycle it is high.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      meas_valid  <= 1'b0;
      period_err  <= 1'b0;
      duty_err    <= 1'b0;
      timeout     <= 1'b0;
      period_meas <= '0;
      high_meas   <= '0;
    end else begin
      meas_valid <= meas_done;
      period_err <= meas_done && (cnt != exp_period);
      duty_err   <= meas_done && (high_meas != exp_high);
      timeout    <= timeout_hit;
      if (meas_done) period_meas <= cnt;
      if (fall_cap)  high_meas   <= hcnt;
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (!en || state_q == ST_IDLE) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_W'(1);
      hcnt <= CNT_W'(1);
    end else if (timeout_hit) begin
      cnt <= '0;
    end else begin
      cnt <= sat_inc(cnt);
      if (state_q == ST_MEAS && div_in) hcnt <= sat_inc(hcnt);
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      good       <= '0;
      err_sticky <= 1'b0;
      rise_count <= '0;
    end else begin
      if (state_d == ST_IDLE || timeout_hit || meas_bad) good <= '0;
      else if (meas_done && good != LOCK_MAX)             good <= good + 4'd1;

      if (state_d == ST_IDLE)           err_sticky <= 1'b0;
      else if (timeout_hit || meas_bad) err_sticky <= 1'b1;

      if (en && rise && state_q != ST_IDLE) rise_count <= rise_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: a clock_gen-like divider drives one monitor through directed
// phases checked by an expected-queue scoreboard; a CNT_W=4 copy watches a div-by-28 clock.
module tb_clk_div_monitor;
  import clk_div_mon_pkg::*;

  localparam int EW = 52;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst  = 1'b0;
  logic rst2 = 1'b0;
  logic en   = 1'b0;
  logic en2  = 1'b1;

  // ---------------- divider models ----------------
  logic [7:0] gen_n   = 8'd2;
  logic [7:0] gen_h   = 8'd1;
  logic [7:0] gen_cnt = 8'd0;
  logic       div_in;
  always @(posedge clk_in) gen_cnt <= (gen_cnt >= gen_n - 8'd1) ? 8'd0 : gen_cnt + 8'd1;
  assign div_in = (gen_cnt < gen_h);

  logic [4:0] gen2_cnt;
  logic       div_in2;
  always @(posedge clk_in or negedge rst2) begin
    if (!rst2) gen2_cnt <= 5'd0;
    else       gen2_cnt <= (gen2_cnt == 5'd27) ? 5'd0 : gen2_cnt + 5'd1;
  end
  assign div_in2 = (gen2_cnt < 5'd14);

  // ---------------- DUTs ----------------
  logic [7:0]  exp_period = 8'd0, exp_high = 8'd0;
  logic [7:0]  period_meas, high_meas;
  logic        meas_valid, period_err, duty_err, err_sticky, locked, timeout;
  logic [31:0] rise_count;
  mon_state_e  state_dbg;

  clk_div_monitor #(.CNT_W(8), .LOCK_CYCLES(4)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .div_in(div_in),
    .exp_period(exp_period), .exp_high(exp_high),
    .period_meas(period_meas), .high_meas(high_meas), .meas_valid(meas_valid),
    .period_err(period_err), .duty_err(duty_err), .err_sticky(err_sticky),
    .locked(locked), .timeout(timeout), .rise_count(rise_count), .state_dbg(state_dbg)
  );

  logic [3:0]  exp_period2 = 4'd12, exp_high2 = 4'd6;
  logic [3:0]  period_meas2, high_meas2;
  logic        meas_valid2, period_err2, duty_err2, err_sticky2, locked2, timeout2;
  logic [31:0] rise_count2;
  mon_state_e  state_dbg2;

  clk_div_monitor #(.CNT_W(4), .LOCK_CYCLES(4)) dut2 (
    .clk_in(clk_in), .rst(rst2), .en(en2), .div_in(div_in2),
    .exp_period(exp_period2), .exp_high(exp_high2),
    .period_meas(period_meas2), .high_meas(high_meas2), .meas_valid(meas_valid2),
    .period_err(period_err2), .duty_err(duty_err2), .err_sticky(err_sticky2),
    .locked(locked2), .timeout(timeout2), .rise_count(rise_count2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  int exp_rises  = 0;
  int exp_good   = 0;
  bit exp_sticky = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entry: {period, high, period_err, duty_err, locked, err_sticky, rise_count}
  task automatic push_meas(input int n, input int h);
    logic pe, de;
    pe = (n != int'(exp_period));
    de = (h != int'(exp_high));
    exp_rises++;
    if (pe || de) begin
      exp_good   = 0;
      exp_sticky = 1'b1;
    end else if (exp_good < 4) begin
      exp_good++;
    end
    exp_q.push_back({8'(n), 8'(h), pe, de, (exp_good == 4), exp_sticky, 32'(exp_rises)});
  endtask

  task automatic drain(input int budget);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < budget) begin
      @(negedge clk_in);
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected measurements missing after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic start_phase(input int n, input int h, input int ep, input int eh);
    gen_n      = 8'(n);
    gen_h      = 8'(h);
    exp_period = 8'(ep);
    exp_high   = 8'(eh);
    repeat (3 * n + 4) @(negedge clk_in);
    en         = 1'b1;
    exp_good   = 0;
    exp_sticky = 1'b0;
    exp_rises++;
  endtask

  task automatic stop_phase();
    en         = 1'b0;
    exp_good   = 0;
    exp_sticky = 1'b0;
  endtask

  logic [EW-1:0] e;
  always @(negedge clk_in) begin
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL meas_unexpected: period %0d high %0d, required no pulse", period_meas, high_meas);
      end else begin
        e = exp_q.pop_front();
        check("period_meas", period_meas, e[51:44]);
        check("high_meas",   high_meas,   e[43:36]);
        check("period_err",  period_err,  e[35]);
        check("duty_err",    duty_err,    e[34]);
        check("locked",      locked,      e[33]);
        check("err_sticky",  err_sticky,  e[32]);
        check("rise_count",  rise_count,  e[31:0]);
      end
    end
  end

  // Timeouts repeat at fixed divider phases: first from the initial ARM, then 15 cycles
  // after each arming rise.
  int n_to = 0, n_mv2 = 0, n_lock2 = 0;
  always @(negedge clk_in) begin
    if (rst2) begin
      if (locked2)     n_lock2++;
      if (meas_valid2) n_mv2++;
      if (timeout2) begin
        check("to_phase",  gen2_cnt, (n_to == 0) ? 17 : 16);
        check("to_state",  state_dbg2, ST_ARM);
        check("to_sticky", err_sticky2, 1);
        n_to++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int found;
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_period_meas", period_meas, 0);
    check("rst_high_meas",   high_meas,   0);
    check("rst_meas_valid",  meas_valid,  0);
    check("rst_err_sticky",  err_sticky,  0);
    check("rst_locked",      locked,      0);
    check("rst_timeout",     timeout,     0);
    check("rst_rise_count",  rise_count,  0);
    check("rst_state",       state_dbg,   ST_IDLE);
    @(negedge clk_in);
    rst  = 1'b1;
    rst2 = 1'b1;

    start_phase(2, 1, 2, 1);
    repeat (6) push_meas(2, 1);
    drain(64);
    stop_phase();

    start_phase(4, 2, 4, 2);
    repeat (6) push_meas(4, 2);
    drain(100);
    stop_phase();

    start_phase(16, 8, 16, 8);
    repeat (6) push_meas(16, 8);
    drain(200);
    stop_phase();

    start_phase(5, 3, 5, 3);
    repeat (5) push_meas(5, 3);
    drain(100);
    exp_high = 8'd2;
    repeat (2) push_meas(5, 3);
    drain(40);

    // Drop en in the cycle whose closing edge carries a rise.
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk_in);
      if (gen_cnt == 8'd0) found = 1;
    end
    check("en_drop_rise_found", found, 1);
    stop_phase();
    @(negedge clk_in);
    check("en_drop_meas_valid", meas_valid, 0);
    check("en_drop_state",      state_dbg,  ST_IDLE);
    check("en_drop_sticky",     err_sticky, 0);
    check("en_drop_locked",     locked,     0);
    check("en_drop_rise_count", rise_count, exp_rises);

    // Reset in the middle of a period, then re-measure from a fresh arming rise.
    exp_high = 8'd3;
    en = 1'b1;
    repeat (3) @(negedge clk_in);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_period_meas", period_meas, 0);
    check("mid_rst_high_meas",   high_meas,   0);
    check("mid_rst_rise_count",  rise_count,  0);
    check("mid_rst_state",       state_dbg,   ST_IDLE);
    check("mid_rst_meas_valid",  meas_valid,  0);
    repeat (2) @(negedge clk_in);
    rst        = 1'b1;
    exp_rises  = 1;
    exp_good   = 0;
    exp_sticky = 1'b0;
    repeat (5) push_meas(5, 3);
    drain(100);
    stop_phase();

    repeat (10) @(negedge clk_in);
    check("dut2_timeouts_ge3", (n_to >= 3), 1);
    check("dut2_meas_pulses",  n_mv2,       0);
    check("dut2_locked_seen",  n_lock2,     0);
    check("dut2_err_sticky",   err_sticky2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Downstream checker for the divided clocks produced by clock_gen (clk_div_2/4/8/16/28/5).
- Samples one selected divided clock as a data signal in the clk_in domain, which is legal because every clock_gen output is generated from clk_in.
- Measures period and high time in clk_in cycles, compares them against expected values, and reports per-period pass/fail, a lock indication, a timeout and a running rise-edge count.
- Used in lab benches and on-board to self-check clock_gen.

Parameters:
- CNT_W, 8: width of period/high counters and expected-value inputs.
- LOCK_CYCLES, 4: consecutive good periods required to assert locked (1..15).

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  monitor enable; low returns the block to IDLE.
- div_in  input  1  divided clock under test, synchronous to clk_in.
- exp_period  input  CNT_W  expected period in clk_in cycles.
- exp_high  input  CNT_W  expected high time in clk_in cycles.
- period_meas  output  CNT_W  last measured period.
- high_meas  output  CNT_W  last measured high time.
- meas_valid  output  1  one-cycle pulse when a measurement completes.
- period_err  output  1  period_meas != exp_period; qualified by meas_valid.
- duty_err  output  1  high_meas != exp_high; qualified by meas_valid.
- err_sticky  output  1  set by any period_err/duty_err/timeout; cleared only in IDLE.
- locked  output  1  LOCK_CYCLES consecutive error-free measurements.
- timeout  output  1  one-cycle pulse when no rise is seen within 2^CNT_W-1 cycles.
- rise_count  output  32  rising edges seen while not in IDLE; wraps modulo 2^32.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, div_q=0, counters 0, state IDLE.
- Edge detection: div_q <= div_in every cycle. rise = div_in & ~div_q; fall = ~div_in & div_q.
- States:
  - IDLE -> ARM when en=1.
  - ARM: wait for the first rise, then go to MEAS; cnt<=1, hcnt<=1. No meas_valid on this first rise.
  - MEAS: per cycle, cnt <= rise ? 1 : sat_inc(cnt).
  - any state -> IDLE when en=0; en=0 has priority over a same-cycle rise or fall.
- Measurement in MEAS:
  - hcnt <= rise ? 1 : (div_in ? sat_inc(hcnt) : hcnt).
  - On fall: high_meas <= hcnt.
  - On rise: period_meas <= cnt, and meas_valid=1 in the next cycle with period_err/duty_err registered alongside.
  - Example, div-by-2: rise every 2 cycles -> period 2, high 1.
- The duty comparison uses high_meas as captured at the fall inside the period just closed.
- Lock: a good counter increments on each error-free meas_valid, saturating at LOCK_CYCLES. locked=1 while good==LOCK_CYCLES. Any error or timeout clears good and locked in the same update.
- Timeout: in ARM or MEAS, if cnt reaches 2^CNT_W-1 with no rise:
  - timeout pulses for one cycle and err_sticky is set;
  - locked is cleared and the state goes to ARM.
  - In ARM, cnt counts from entry.
- rise_count increments on every rise while the state is not IDLE, including the arming rise.
- Changing exp_* mid-run affects only comparisons made after the change; the block is not re-armed.
- Reset asserted mid-period: immediate clear; the first measurement after release requires a fresh arming rise.

Decomposition:
- Package clk_div_mon_pkg holds:
  - state encoding IDLE/ARM/MEAS (2-bit);
  - default CNT_W and LOCK_CYCLES;
  - ROLL_W=32.
- One sub-module, div_edge_det: registers div_in and emits rise/fall. Shared with future clock checkers.
- Counters, comparisons and the FSM stay in the top level.

Test Plan:
- Connect clk_div_2, exp_period=2, exp_high=1, en=1 after reset -> meas_valid every 2 cycles, no errors, locked after 4 valid pulses, rise_count increments per rise.
- Connect clk_div_4 (4/2), then clk_div_16 (16/8) -> each case locks with period_meas 4 or 16 and high_meas 2 or 8; err_sticky stays 0.
- Connect clk_div_5 with exp_period=5, exp_high=3 (matching the generator's duty) -> locked. Then set exp_high=2 -> next meas_valid has duty_err=1, locked drops, err_sticky=1.
- CNT_W=4 with clk_div_28 -> timeout pulses at cnt=15, state returns to ARM, locked never set, err_sticky=1.
- Assert rst (low) mid-period, then release -> all outputs 0, and the first meas_valid comes only one full period after the arming rise.
- Drop en coincident with a rise -> no meas_valid, state IDLE, err_sticky cleared, rise_count holds.
